fpu_share_arbiter: RTL and testbench
====================================

// Module: fpu_share_arbiter
// PURPOSE
//  Shares one FPU datapath block (dpi/fpnew/dsp core + tag store) between NUM_REQS issue requesters.
//  Round-robin grant with packet lock (sop..eop kept contiguous), tag allocation from a free pool,
//  per-requester outstanding quota, and tag-indexed routing of out-of-order FPU responses back
//  to the owning requester. Sits between the per-issue dispatch outputs and a shared FPU block.
// PARAMETERS
//  NUM_REQS   4   number of requesters sharing the FPU (>=1)
//  REQ_DATAW  64  opaque request payload width (op, fmt, frm, operands, metadata)
//  RSP_DATAW  64  opaque response payload width (result, fflags)
//  TAG_WIDTH  3   FPU tag width; tag pool holds 2**TAG_WIDTH entries
//  QUOTA      4   max in-flight requests per requester (1..2**TAG_WIDTH)
// PORTS
//  clk            in   1                    clock, all state on rising edge
//  reset_n        in   1                    asynchronous reset, active-low
//  req_valid      in   NUM_REQS             requester i has a request
//  req_eop        in   NUM_REQS             request is last packet of its instruction
//  req_data       in   NUM_REQS*REQ_DATAW   request payloads
//  req_ready      out  NUM_REQS             request i accepted this cycle when valid&ready
//  fpu_req_valid  out  1                    request to FPU
//  fpu_req_data   out  REQ_DATAW            granted payload
//  fpu_req_tag    out  TAG_WIDTH            allocated tag
//  fpu_req_ready  in   1                    FPU accepts
//  fpu_rsp_valid  in   1                    FPU response
//  fpu_rsp_data   in   RSP_DATAW            response payload
//  fpu_rsp_tag    in   TAG_WIDTH            tag of response
//  fpu_rsp_ready  out  1                    response consumed
//  rsp_valid      out  NUM_REQS             routed response for requester i (one-hot or 0)
//  rsp_data       out  RSP_DATAW            fpu_rsp_data, shared by all requesters
//  rsp_ready      in   NUM_REQS             requester i accepts
//  inflight       out  TAG_WIDTH+1          tags currently allocated
// BEHAVIOUR
//  - Reset (reset_n low, async): free_mask all-ones, owner table cleared, per-req counts 0,
//    rr_ptr 0, FSM IDLE, inflight 0. While reset_n low: req_ready, fpu_req_valid, rsp_valid,
//    fpu_rsp_ready all 0. Reset mid-operation discards all in-flight tags; FPU must reset with it.
//  - Eligible(i) = req_valid[i] & (cnt[i] < QUOTA) & (free_mask != 0).
//  - FSM IDLE: pick first eligible i from rr_ptr upward (wrapping). fpu_req_valid=1, data/tag from
//    i, tag = lowest set bit of registered free_mask. req_ready[i]=fpu_req_ready, others 0.
//    Zero-cycle path: valid/data/ready are combinational, no request latency.
//  - On fire (fpu_req_valid & fpu_req_ready): clear free_mask[tag], owner[tag]<=i, cnt[i]++,
//    rr_ptr<=(i+1)%NUM_REQS only when req_eop[i]; if !req_eop[i] go LOCKED(owner=i).
//  - FSM LOCKED(i): only i may be granted (even if others eligible); return IDLE on fire with eop.
//    Quota/pool exhaustion in LOCKED stalls i; no other requester is served meanwhile.
//  - Response: o=owner[fpu_rsp_tag]. rsp_valid[o]=fpu_rsp_valid, fpu_rsp_ready=rsp_ready[o]
//    (combinational, 0 latency). On rsp fire: set free_mask[tag], cnt[o]--.
//  - Response with tag not allocated: fpu_rsp_ready=1, rsp_valid all 0 (dropped); assert in sim.
//  - Same-cycle alloc+free: alloc uses pre-edge free_mask; freed tag reusable next cycle only.
//    Same requester alloc+free same cycle: cnt[i] unchanged. inflight = popcount(~free_mask).
//  - cnt width clog2(QUOTA+1); cnt never exceeds QUOTA nor underflows (asserted).
//  - Holding req_data/req_valid stable until ready is required of requesters; not checked here.
// TESTING
//  1 Reset: reset_n low mid-traffic -> all valid/ready outs 0 immediately, inflight 0 after release.
//  2 RR: NUM_REQS=4, all valid, eop=1, fpu_req_ready=1, no rsp -> grants 0,1,2,3, tags 0,1,2,3.
//  3 Lock: req0 sends sop,mid,eop (eop on 3rd) with req1 valid -> req0 granted 3 cycles, then req1.
//  4 Quota: QUOTA=2, only req2 valid, no rsp -> 2 grants then req_ready[2]=0; one rsp -> 1 more grant.
//  5 Pool: TAG_WIDTH=2, 4 allocs outstanding -> fpu_req_valid=0; free tag 2 -> next grant uses tag 2.
//  6 OOO routing: tags 0(req1),1(req3) out; rsp tag1 then tag0, rsp_ready[3]=0 for 2 cycles ->
//    rsp_valid[3] held, fpu_rsp_ready=0 until accepted; then rsp_valid[1] with tag0 data.

Source files
------------

// File: rtl/fpu_share_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_share_arbiter
//
// Shares one FPU datapath between NUM_REQS issue requesters. Grants are
// round-robin, but a multi-packet instruction (sop..eop) stays contiguous
// because the arbiter locks onto its requester until eop is accepted. Each
// accepted request takes a tag from a free pool. The owner of each tag is
// recorded so that out-of-order FPU responses go back to the right requester.
// A per-requester count limits how many requests each one may have in flight.
//
// Ports
//   clk, reset_n                      clock / asynchronous active-low reset
//   req_valid/req_eop/req_data        per-requester request inputs
//   req_ready                         per-requester accept (valid&ready = taken)
//   fpu_req_valid/data/tag, ready     request channel to the shared FPU
//   fpu_rsp_valid/data/tag, ready     response channel from the shared FPU
//   rsp_valid/rsp_data, rsp_ready     routed responses (rsp_data is shared)
//   inflight                          number of tags currently allocated
// -----------------------------------------------------------------------------
module fpu_share_arbiter #(
    parameter int NUM_REQS  = 4,
    parameter int REQ_DATAW = 64,
    parameter int RSP_DATAW = 64,
    parameter int TAG_WIDTH = 3,
    parameter int QUOTA     = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS-1:0]           req_eop,
    input  logic [NUM_REQS*REQ_DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          fpu_req_valid,
    output logic [REQ_DATAW-1:0]          fpu_req_data,
    output logic [TAG_WIDTH-1:0]          fpu_req_tag,
    input  logic                          fpu_req_ready,
    input  logic                          fpu_rsp_valid,
    input  logic [RSP_DATAW-1:0]          fpu_rsp_data,
    input  logic [TAG_WIDTH-1:0]          fpu_rsp_tag,
    output logic                          fpu_rsp_ready,
    output logic [NUM_REQS-1:0]           rsp_valid,
    output logic [RSP_DATAW-1:0]          rsp_data,
    input  logic [NUM_REQS-1:0]           rsp_ready,
    output logic [TAG_WIDTH:0]            inflight
);

    localparam int NUM_TAGS = 1 << TAG_WIDTH;
    localparam int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int CNT_W    = $clog2(QUOTA + 1);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t              state_reg;
    logic [IDX_W-1:0]    lock_id_reg;
    logic [IDX_W-1:0]    rr_ptr_reg;
    logic [NUM_TAGS-1:0] free_mask_reg;
    logic [IDX_W-1:0]    owner_reg [NUM_TAGS];
    logic [CNT_W-1:0]    cnt_reg   [NUM_REQS];

    logic                pool_avail;
    logic [NUM_REQS-1:0] elig;
    logic                gnt_found;
    logic [IDX_W-1:0]    gnt_idx;
    logic [TAG_WIDTH-1:0] alloc_tag;
    logic                req_fire;
    logic [IDX_W-1:0]    rsp_owner;
    logic                rsp_alloc;
    logic                rsp_fire;
    logic [IDX_W-1:0]    next_ptr;
    int                  pick_idx;

    assign pool_avail = |free_mask_reg;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_elig
        assign elig[gi] = req_valid[gi] & (cnt_reg[gi] < CNT_W'(QUOTA)) & pool_avail;
    end

    // Arbitration: locked requester only, otherwise first eligible from
    // rr_ptr upward. Scanning k downward lets the smallest offset win.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pick_idx  = 0;
        if (state_reg == ST_LOCKED) begin
            gnt_found = elig[lock_id_reg];
            gnt_idx   = lock_id_reg;
        end else begin
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                pick_idx = int'(rr_ptr_reg) + k;
                if (pick_idx >= NUM_REQS) pick_idx = pick_idx - NUM_REQS;
                if (elig[IDX_W'(pick_idx)]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IDX_W'(pick_idx);
                end
            end
        end
    end

    // Lowest free tag from the registered pool.
    always_comb begin
        alloc_tag = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (free_mask_reg[t]) alloc_tag = TAG_WIDTH'(t);
        end
    end

    assign fpu_req_valid = reset_n & gnt_found;
    assign fpu_req_data  = req_data[gnt_idx*REQ_DATAW +: REQ_DATAW];
    assign fpu_req_tag   = alloc_tag;
    assign req_fire      = fpu_req_valid & fpu_req_ready;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
        assign req_ready[gi] = req_fire & (gnt_idx == IDX_W'(gi));
    end

    // Response routing. A tag that is still marked free has no owner, so
    // the response is swallowed instead of being delivered to anyone.
    assign rsp_owner     = owner_reg[fpu_rsp_tag];
    assign rsp_alloc     = ~free_mask_reg[fpu_rsp_tag];
    assign fpu_rsp_ready = reset_n & (rsp_alloc ? rsp_ready[rsp_owner] : 1'b1);
    assign rsp_fire      = fpu_rsp_valid & fpu_rsp_ready & rsp_alloc;
    assign rsp_data      = fpu_rsp_data;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_rsp
        assign rsp_valid[gi] = reset_n & fpu_rsp_valid & rsp_alloc &
                               (rsp_owner == IDX_W'(gi));
    end

    always_comb begin
        inflight = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            inflight = inflight + (TAG_WIDTH + 1)'(!free_mask_reg[t]);
        end
    end

    assign next_ptr = (gnt_idx == IDX_W'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            lock_id_reg   <= '0;
            rr_ptr_reg    <= '0;
            free_mask_reg <= '1;
            for (int t = 0; t < NUM_TAGS; t++) owner_reg[t] <= '0;
            for (int i = 0; i < NUM_REQS; i++) cnt_reg[i] <= '0;
        end else begin
            // Alloc and free never hit the same tag: alloc takes a free
            // tag, a response can only free an allocated one.
            free_mask_reg <= (free_mask_reg & ~(req_fire ? (NUM_TAGS'(1) << alloc_tag) : '0))
                           | (rsp_fire ? (NUM_TAGS'(1) << fpu_rsp_tag) : '0);
            if (req_fire) begin
                owner_reg[alloc_tag] <= gnt_idx;
                if (req_eop[gnt_idx]) begin
                    state_reg  <= ST_IDLE;
                    rr_ptr_reg <= next_ptr;
                end else begin
                    state_reg   <= ST_LOCKED;
                    lock_id_reg <= gnt_idx;
                end
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                case ({req_fire && (gnt_idx == IDX_W'(i)), rsp_fire && (rsp_owner == IDX_W'(i))})
                    2'b10:   cnt_reg[i] <= cnt_reg[i] + 1'b1;
                    2'b01:   cnt_reg[i] <= cnt_reg[i] - 1'b1;
                    default: cnt_reg[i] <= cnt_reg[i];
                endcase
            end
        end
    end

    a_rsp_tag_alloc: assert property (@(posedge clk) disable iff (!reset_n)
        fpu_rsp_valid |-> rsp_alloc);
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        rsp_fire |-> (cnt_reg[rsp_owner] != '0));
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_cnt_chk
        a_cnt_quota: assert property (@(posedge clk) disable iff (!reset_n)
            cnt_reg[gi] <= CNT_W'(QUOTA));
    end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_share_arbiter
//
// Drives the arbiter with directed and random traffic. A small model holds
// the tag pool, owners, per-requester counts, rr pointer and lock. Every
// cycle it predicts the outputs and compares them with the DUT. Directed
// scenarios also pin literal expectations.
// -----------------------------------------------------------------------------
module tb_fpu_share_arbiter;

    localparam int NR = 4;
    localparam int RW = 32;
    localparam int SW = 32;
    localparam int TW = 2;
    localparam int Q  = 2;
    localparam int NT = 1 << TW;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR-1:0]  req_eop = '0;
    logic [NR*RW-1:0] req_data = '0;
    logic [NR-1:0]  req_ready;
    logic           fpu_req_valid;
    logic [RW-1:0]  fpu_req_data;
    logic [TW-1:0]  fpu_req_tag;
    logic           fpu_req_ready = 1'b0;
    logic           fpu_rsp_valid = 1'b0;
    logic [SW-1:0]  fpu_rsp_data = '0;
    logic [TW-1:0]  fpu_rsp_tag = '0;
    logic           fpu_rsp_ready;
    logic [NR-1:0]  rsp_valid;
    logic [SW-1:0]  rsp_data;
    logic [NR-1:0]  rsp_ready = '0;
    logic [TW:0]    inflight;

    fpu_share_arbiter #(
        .NUM_REQS(NR), .REQ_DATAW(RW), .RSP_DATAW(SW), .TAG_WIDTH(TW), .QUOTA(Q)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_eop(req_eop), .req_data(req_data), .req_ready(req_ready),
        .fpu_req_valid(fpu_req_valid), .fpu_req_data(fpu_req_data), .fpu_req_tag(fpu_req_tag),
        .fpu_req_ready(fpu_req_ready),
        .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_data(fpu_rsp_data), .fpu_rsp_tag(fpu_rsp_tag),
        .fpu_rsp_ready(fpu_rsp_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Model state
    bit m_free  [NT];
    int m_owner [NT];
    int m_cnt   [NR];
    int m_rr;
    bit m_lock;
    int m_lid;

    // Pre-edge samples of the last cycle
    logic [NR-1:0] s_rr, s_rspv;
    logic          s_fv, s_frr;
    logic [TW-1:0] s_tag;
    logic [SW-1:0] s_rdata, d_rspdata;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin m_free[t] = 1'b1; m_owner[t] = 0; end
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_rr = 0; m_lock = 1'b0; m_lid = 0;
    endtask

    // One clock cycle: drive, predict, compare, advance the model.
    task automatic cycle(input logic [NR-1:0] rv, input logic [NR-1:0] eop, input bit frr,
                         input bit rspv, input int rtag, input logic [NR-1:0] rrdy);
        int  g, t, o, busy;
        bit  alloc;
        @(negedge clk);
        req_valid = rv;
        req_eop   = eop;
        for (int i = 0; i < NR; i++) req_data[i*RW +: RW] = $urandom;
        fpu_req_ready = frr;
        fpu_rsp_valid = rspv;
        fpu_rsp_tag   = rtag[TW-1:0];
        fpu_rsp_data  = $urandom;
        d_rspdata     = fpu_rsp_data;
        rsp_ready     = rrdy;
        #1;
        g = -1; t = -1; busy = 0;
        for (int k = NT - 1; k >= 0; k--) if (m_free[k]) t = k;
        for (int k = 0; k < NT; k++) if (!m_free[k]) busy++;
        if (m_lock) begin
            if (rv[m_lid] && m_cnt[m_lid] < Q && t >= 0) g = m_lid;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int i = (m_rr + k) % NR;
                if (g < 0 && rv[i] && m_cnt[i] < Q && t >= 0) g = i;
            end
        end
        alloc = !m_free[rtag];
        o     = m_owner[rtag];

        check("fpu_req_valid", fpu_req_valid, 64'(g >= 0));
        check("req_ready", req_ready, (g >= 0 && frr) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
            check("fpu_req_data", fpu_req_data, req_data[g*RW +: RW]);
            check("fpu_req_tag", fpu_req_tag, t);
        end
        check("rsp_valid", rsp_valid, (rspv && alloc) ? (64'd1 << o) : 64'd0);
        check("fpu_rsp_ready", fpu_rsp_ready, alloc ? 64'(rrdy[o]) : 64'd1);
        if (rspv && alloc) check("rsp_data", rsp_data, fpu_rsp_data);
        check("inflight", inflight, busy);

        s_rr = req_ready; s_fv = fpu_req_valid; s_tag = fpu_req_tag;
        s_rspv = rsp_valid; s_frr = fpu_rsp_ready; s_rdata = rsp_data;

        if (rspv && alloc && rrdy[o]) begin
            m_free[rtag] = 1'b1;
            m_cnt[o]--;
        end
        if (g >= 0 && frr) begin
            m_free[t] = 1'b0;
            m_owner[t] = g;
            m_cnt[g]++;
            if (eop[g]) begin m_rr = (g + 1) % NR; m_lock = 1'b0; end
            else begin m_lock = 1'b1; m_lid = g; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '1; req_eop = '1; fpu_req_ready = 1'b1;
        fpu_rsp_valid = 1'b1; rsp_ready = '1;
        reset_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_fpu_req_valid", fpu_req_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_fpu_rsp_ready", fpu_rsp_ready, 0);
        repeat (2) @(negedge clk);
        req_valid = '0; fpu_rsp_valid = 1'b0; fpu_req_ready = 1'b0; rsp_ready = '0;
        reset_n = 1'b1;
        model_reset();
        #1;
        check("rst_inflight", inflight, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            int tg = -1;
            for (int k = NT - 1; k >= 0; k--) if (!m_free[k]) tg = k;
            if (tg < 0) break;
            cycle('0, '0, 1'b0, 1'b1, tg, '1);
        end
        @(posedge clk); #1;
        check("drain_inflight", inflight, 0);
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            logic [NR-1:0] eop;
            int alist[$];
            bit rspv;
            int rtag;
            for (int i = 0; i < NR; i++) eop[i] = ($urandom_range(9) < 7);
            for (int k = 0; k < NT; k++) if (!m_free[k]) alist.push_back(k);
            rspv = (alist.size() > 0) && ($urandom_range(99) < 60);
            rtag = rspv ? alist[$urandom_range(alist.size() - 1)] : int'($urandom_range(NT - 1));
            if (!rspv && !m_free[rtag]) rtag = rtag;
            cycle(NR'($urandom), eop, ($urandom_range(3) != 0), rspv, rtag,
                  NR'($urandom | $urandom));
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Round robin, all eop, tags ascending
        for (int k = 0; k < 4; k++) begin
            cycle(4'hF, 4'hF, 1'b1, 1'b0, 0, 4'hF);
            check($sformatf("rr_grant%0d", k), s_rr, 64'd1 << k);
            check($sformatf("rr_tag%0d", k), s_tag, k);
        end

        // Pool exhausted, then tag 2 freed and reused
        cycle(4'hF, 4'hF, 1'b1, 1'b0, 0, 4'hF);
        check("pool_empty_valid", s_fv, 0);
        cycle(4'h0, 4'hF, 1'b1, 1'b1, 2, 4'hF);
        check("pool_free_rsp", s_rspv, 4'b0100);
        cycle(4'hF, 4'hF, 1'b1, 1'b0, 0, 4'hF);
        check("pool_reuse_tag", s_tag, 2);
        check("pool_reuse_grant", s_rr, 4'b0001);
        drain();

        // Quota: req2 alone, two grants then stall, one response frees a slot
        cycle(4'b0100, 4'hF, 1'b1, 1'b0, 0, 4'hF);
        check("quota_g1", s_rr, 4'b0100);
        cycle(4'b0100, 4'hF, 1'b1, 1'b0, 0, 4'hF);
        check("quota_g2", s_rr, 4'b0100);
        cycle(4'b0100, 4'hF, 1'b1, 1'b0, 0, 4'hF);
        check("quota_stall", s_rr, 4'b0000);
        check("quota_stall_valid", s_fv, 0);
        cycle(4'b0100, 4'hF, 1'b1, 1'b1, 0, 4'hF);
        check("quota_rsp_cycle", s_rr, 4'b0000);
        cycle(4'b0100, 4'hF, 1'b1, 1'b0, 0, 4'hF);
        check("quota_regrant", s_rr, 4'b0100);
        check("quota_regrant_tag", s_tag, 0);
        drain();

        // Packet lock: req0 sop, mid, eop while req1 waits
        cycle(4'b0011, 4'b0000, 1'b1, 1'b0, 0, 4'hF);
        check("lock_sop", s_rr, 4'b0001);
        cycle(4'b0011, 4'b0000, 1'b1, 1'b1, 0, 4'hF);
        check("lock_mid", s_rr, 4'b0001);
        cycle(4'b0011, 4'b0001, 1'b1, 1'b0, 0, 4'hF);
        check("lock_eop", s_rr, 4'b0001);
        cycle(4'b0011, 4'b0011, 1'b1, 1'b0, 0, 4'hF);
        check("lock_next", s_rr, 4'b0010);
        drain();

        // Out-of-order routing with backpressure
        cycle(4'b0010, 4'hF, 1'b1, 1'b0, 0, 4'hF);
        check("ooo_g1", s_rr, 4'b0010);
        check("ooo_t0", s_tag, 0);
        cycle(4'b1000, 4'hF, 1'b1, 1'b0, 0, 4'hF);
        check("ooo_g3", s_rr, 4'b1000);
        check("ooo_t1", s_tag, 1);
        for (int k = 0; k < 2; k++) begin
            cycle('0, '0, 1'b0, 1'b1, 1, 4'b0111);
            check("ooo_hold_valid", s_rspv, 4'b1000);
            check("ooo_hold_ready", s_frr, 0);
        end
        cycle('0, '0, 1'b0, 1'b1, 1, 4'hF);
        check("ooo_acc_valid", s_rspv, 4'b1000);
        check("ooo_acc_ready", s_frr, 1);
        cycle('0, '0, 1'b0, 1'b1, 0, 4'hF);
        check("ooo_r1_valid", s_rspv, 4'b0010);
        check("ooo_r1_data", s_rdata, d_rspdata);
        drain();

        // Random traffic, reset mid-stream, more random traffic
        rand_cycles(1500);
        do_reset();
        rand_cycles(1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
